// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared state codes and defaults for the uart tx scheduler
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int DEF_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rtl/uart_tx_sched_rr_pick.sv - combinational rotating-priority picker (first valid at or after ptr)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int o = 0; o < NREQ; o++) begin
            j = (int'(ptr) + o) % NREQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart transmitter between NREQ producers
// Optional channel locking is enabled with UART_TX_SCHED_LOCK_EN.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int IDW          = 2,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic [IDW-1:0]    grant_id,
    output logic              sched_idle,
    output logic              timeout
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    sched_state_t    state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  pick_ptr;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_valid;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any;
    logic            lock_active;
    logic            lock_take;
    logic [CW-1:0]   cnt;
    logic [7:0]      pick_byte;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] g);
        return (int'(g) >= NREQ - 1) ? '0 : g + 1'b1;
    endfunction

`ifdef UART_TX_SCHED_LOCK_EN
    logic [NREQ-1:0] gid_mask;

    always_comb begin
        gid_mask = '0;
        for (int i = 0; i < NREQ; i++)
            if (int'(grant_id) == i) gid_mask[i] = 1'b1;
    end

    // A held lock narrows eligibility to its owner; once dropped, arbitration restarts after it
    assign pick_valid = (lock_active && |(gid_mask & req_valid & req_lock)) ? gid_mask : req_valid;
    assign pick_ptr   = lock_active ? next_id(grant_id) : ptr;
    assign lock_take  = |(pick_grant & req_lock);
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign pick_valid  = req_valid;
    assign pick_ptr    = ptr;
    assign lock_take   = 1'b0;
`endif

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (pick_valid),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick_grant[i]) pick_byte = req_data[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            lock_active <= 1'b0;
            tx_wr       <= 1'b0;
            tx_data     <= '0;
            req_ready   <= '0;
            grant_id    <= '0;
            sched_idle  <= 1'b1;
            timeout     <= 1'b0;
        end else begin
            tx_wr     <= 1'b0;
            req_ready <= '0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_busy && pick_any) begin
                        tx_data     <= pick_byte;
                        grant_id    <= pick_idx;
                        req_ready   <= pick_grant;
                        tx_wr       <= 1'b1;
                        lock_active <= lock_take;
                        sched_idle  <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        // The uart never acknowledged: give up, drop any lock and move on
                        timeout     <= 1'b1;
                        ptr         <= next_id(grant_id);
                        lock_active <= 1'b0;
                        sched_idle  <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (!lock_active) ptr <= next_id(grant_id);
                        sched_idle <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched with a simple uart busy model
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        sched_idle;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    logic force_busy = 1'b0;
    int   busy_len   = 10;
    int   busy_cnt   = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[10];
    logic [1:0] lk_gid[4];
    logic [7:0] lk_data[4];

    uart_tx_sched #(.NREQ(4), .IDW(2), .BUSY_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .sched_idle (sched_idle),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // uart model: busy for busy_len cycles after each write strobe (never, if busy_len is 0)
    always @(posedge clk) begin
        if (tx_wr && busy_len > 0) busy_cnt <= busy_len;
        else if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        req_valid  = '0;
        req_lock   = '0;
        req_data   = '0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_wr(input string name, input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!tx_wr && cyc < max);
        check({name, "_wr_seen"}, tx_wr, 1'b1);
    endtask

    task automatic wait_idle(input string name, input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sched_idle && cyc < max);
        check({name, "_idle_seen"}, sched_idle, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int cyc;
        int wr_seen;
        int n1;

        vecs[0] = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
        vecs[1] = '{4'b1111, 32'h13121110, 2'd1, 8'h11};
        vecs[2] = '{4'b1111, 32'h13121110, 2'd2, 8'h12};
        vecs[3] = '{4'b1111, 32'h13121110, 2'd3, 8'h13};
        vecs[4] = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
        vecs[5] = '{4'b1000, 32'hD3C2B1A0, 2'd3, 8'hD3};
        vecs[6] = '{4'b0101, 32'hD3C2B1A0, 2'd0, 8'hA0};
        vecs[7] = '{4'b0100, 32'hD3C2B1A0, 2'd2, 8'hC2};
        vecs[8] = '{4'b0011, 32'hD3C2B1A0, 2'd0, 8'hA0};
        vecs[9] = '{4'b1010, 32'hD3C2B1A0, 2'd1, 8'hB1};

`ifdef UART_TX_SCHED_LOCK_EN
        lk_gid[0] = 2'd1; lk_data[0] = 8'hB1;
        lk_gid[1] = 2'd1; lk_data[1] = 8'hB2;
        lk_gid[2] = 2'd1; lk_data[2] = 8'hB3;
        lk_gid[3] = 2'd0; lk_data[3] = 8'hA0;
`else
        lk_gid[0] = 2'd1; lk_data[0] = 8'hB1;
        lk_gid[1] = 2'd0; lk_data[1] = 8'hA0;
        lk_gid[2] = 2'd1; lk_data[2] = 8'hB2;
        lk_gid[3] = 2'd1; lk_data[3] = 8'hB3;
`endif

        reset     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_data  = '0;
        do_reset();

        check("rst_tx_wr",      tx_wr,      1'b0);
        check("rst_tx_data",    tx_data,    8'h00);
        check("rst_req_ready",  req_ready,  4'b0000);
        check("rst_grant_id",   grant_id,   2'd0);
        check("rst_sched_idle", sched_idle, 1'b1);
        check("rst_timeout",    timeout,    1'b0);

        // single byte from requester 0
        req_valid = 4'b0001;
        req_data  = 32'h00000041;
        wait_wr("t1", 20, cyc);
        check("t1_latency",   cyc,        1);
        check("t1_tx_data",   tx_data,    8'h41);
        check("t1_req_ready", req_ready,  4'b0001);
        check("t1_grant_id",  grant_id,   2'd0);
        check("t1_not_idle",  sched_idle, 1'b0);
        req_valid = '0;
        @(negedge clk);
        check("t1_wr_pulse",    tx_wr,     1'b0);
        check("t1_ready_pulse", req_ready, 4'b0000);
        wait_idle("t1", 40, cyc);
        check("t1_idle_after_busy", cyc + 1, 12);
        check("t1_busy_low", tx_busy, 1'b0);

        // table: round-robin rotation and pointer wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            wait_wr($sformatf("rr%0d", i), 20, cyc);
            check($sformatf("rr%0d_latency", i), cyc, 1);
            check($sformatf("rr%0d_gid", i), grant_id, vecs[i].exp_gid);
            check($sformatf("rr%0d_data", i), tx_data, vecs[i].exp_data);
            check($sformatf("rr%0d_ready", i), req_ready, 4'b0001 << vecs[i].exp_gid);
            if (i == 9) req_valid = '0;
            wait_idle($sformatf("rr%0d", i), 40, cyc);
        end

        // uart busy before the request holds off the grant
        force_busy = 1'b1;
        req_valid  = 4'b0100;
        req_data   = 32'h00770000;
        wr_seen    = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_wr) wr_seen++;
        end
        check("busy_no_wr", wr_seen, 0);
        check("busy_still_idle", sched_idle, 1'b1);
        force_busy = 1'b0;
        wait_wr("busy", 20, cyc);
        check("busy_latency", cyc, 1);
        check("busy_data", tx_data, 8'h77);
        check("busy_gid", grant_id, 2'd2);
        req_valid = '0;
        wait_idle("busy", 40, cyc);

        // tx_busy never rises: timeout then pointer advance
        do_reset();
        busy_len  = 0;
        req_valid = 4'b0001;
        req_data  = 32'h00000055;
        wait_wr("to", 20, cyc);
        req_valid = '0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!timeout && cyc < 40);
        check("to_pulse_seen", timeout, 1'b1);
        check("to_delay", cyc, 17);
        check("to_idle", sched_idle, 1'b1);
        busy_len  = 10;
        req_valid = 4'b0011;
        req_data  = 32'h00009955;
        @(negedge clk);
        check("to_pulse_one_cycle", timeout, 1'b0);
        check("to_next_wr", tx_wr, 1'b1);
        check("to_next_gid", grant_id, 2'd1);
        check("to_next_data", tx_data, 8'h99);
        req_valid = '0;
        wait_idle("to", 40, cyc);

        // reset during WAIT_DONE
        req_valid = 4'b0100;
        req_data  = 32'h00660000;
        wait_wr("mr_a", 20, cyc);
        req_valid = '0;
        wait_idle("mr_a", 40, cyc);
        req_valid = 4'b0100;
        wait_wr("mr_b", 20, cyc);
        check("mr_b_gid", grant_id, 2'd2);
        req_valid = 4'b1100;
        req_data  = 32'h68670000;
        repeat (4) @(negedge clk);
        check("mr_in_wait_done", {sched_idle, tx_busy}, 2'b01);
        #2 reset = 1'b0;
        #1;
        check("mr_rst_tx_wr",      tx_wr,      1'b0);
        check("mr_rst_req_ready",  req_ready,  4'b0000);
        check("mr_rst_tx_data",    tx_data,    8'h00);
        check("mr_rst_grant_id",   grant_id,   2'd0);
        check("mr_rst_sched_idle", sched_idle, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        wait_wr("mr_c", 40, cyc);
        check("mr_c_gid", grant_id, 2'd2);
        check("mr_c_data", tx_data, 8'h67);
        req_valid = '0;
        wait_idle("mr_c", 40, cyc);

        // locked multi-byte message from requester 1 against requester 0
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h000000A0;
        wait_wr("lk_pre", 20, cyc);
        req_valid = '0;
        wait_idle("lk_pre", 40, cyc);
        req_data  = 32'h0000B1A0;
        req_valid = 4'b0011;
        req_lock  = 4'b0010;
        n1 = 0;
        for (int n = 0; n < 4; n++) begin
            wait_wr($sformatf("lk%0d", n), 40, cyc);
            check($sformatf("lk%0d_gid", n), grant_id, lk_gid[n]);
            check($sformatf("lk%0d_data", n), tx_data, lk_data[n]);
            if (grant_id == 2'd1) begin
                n1++;
                if (n1 == 3) begin
                    req_valid[1] = 1'b0;
                    req_lock[1]  = 1'b0;
                end else begin
                    req_data[15:8] = 8'hB1 + 8'(n1);
                end
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        wait_idle("lk_end", 40, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
